// File: rtl/pyth_pkg.sv
// Shared constants for the Pythagorean-leg solver.
//   Width   : operand/result width; squares and differences are 2*Width bits
//   CntW    : width of the root-extraction bit counter
//   St*     : FSM state encoding (CAPTURE -> DIFF -> ITER -> OUTPUT)
package pyth_pkg;

    localparam int unsigned Width = 8;
    localparam int unsigned CntW  = (Width > 1) ? $clog2(Width) : 1;

    localparam logic [1:0] StCapture = 2'd0;
    localparam logic [1:0] StDiff    = 2'd1;
    localparam logic [1:0] StIter    = 2'd2;
    localparam logic [1:0] StOutput  = 2'd3;

endpackage

// File: rtl/pyth_if.sv
// Pin bundle of the TT user slot.
//   ena     : enable, low freezes the design
//   ui_in   : r, hypotenuse
//   uio_in  : x, known leg
//   uo_out  : y, computed leg
//   uio_out : always zero
//   uio_oe  : always zero (uio bank is input-only)
// master = harness/testbench side, slave = design side.
interface pyth_if;

    logic                       ena;
    logic [pyth_pkg::Width-1:0] ui_in;
    logic [pyth_pkg::Width-1:0] uio_in;
    logic [pyth_pkg::Width-1:0] uo_out;
    logic [pyth_pkg::Width-1:0] uio_out;
    logic [pyth_pkg::Width-1:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );

endinterface

// File: rtl/isqrt_seq.sv
// Sequential digit-by-digit restoring integer square root, one result bit per
// enabled cycle, MSB first.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena_i      : advance enable; low holds all state
//   start_i    : clear root/remainder and arm WIDTH iterations (diff_i must be
//                stable from the next enabled cycle onward)
//   diff_i     : radicand, 2*WIDTH bits
//   root_o     : floor(sqrt(diff_i)) once finished
//   rem_o      : diff_i - root_o^2 once finished
//   done_o     : high while the final iteration is pending (next enabled edge
//                completes the root)
module isqrt_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena_i,
    input  logic               start_i,
    input  logic [2*WIDTH-1:0] diff_i,
    output logic [WIDTH-1:0]   root_o,
    output logic [2*WIDTH:0]   rem_o,
    output logic               done_o
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0]   root_q, root_d;
    logic [2*WIDTH:0]   rem_q, rem_d;
    logic [CntW-1:0]    cnt_q;
    logic               busy_q;

    logic [2*WIDTH-1:0] diff_sh;
    logic [2*WIDTH:0]   rem_sh;
    logic [2*WIDTH:0]   trial;

    // Bring the next pair of radicand bits into the remainder and try
    // appending a 1 to the root: trial = 4*root + 1.
    always_comb begin
        diff_sh = diff_i >> {cnt_q, 1'b0};
        rem_sh  = {rem_q[2*WIDTH-2:0], diff_sh[1:0]};
        trial   = {{(WIDTH-1){1'b0}}, root_q, 2'b01};
        if (rem_sh >= trial) begin
            rem_d  = rem_sh - trial;
            root_d = {root_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d  = rem_sh;
            root_d = {root_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            root_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (ena_i) begin
            if (start_i) begin
                root_q <= '0;
                rem_q  <= '0;
                cnt_q  <= CntW'(WIDTH - 1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                root_q <= root_d;
                rem_q  <= rem_d;
                cnt_q  <= cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    busy_q <= 1'b0;
                end
            end
        end
    end

    assign root_o = root_q;
    assign rem_o  = rem_q;
    assign done_o = busy_q && (cnt_q == '0);

endmodule

// File: rtl/tt_um_pyth_leg.sv
// TT user module: given hypotenuse r (ui_in) and leg x (uio_in) returns the
// other leg y = floor(sqrt(max(r^2 - x^2, 0))) on uo_out, recomputed every
// Width+3 enabled cycles. Pins are sampled only in CAPTURE.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pin bundle (ena, ui_in, uio_in, uo_out, uio_out, uio_oe)
// Build option PYTH_LEG_ROUND_EN: round y to nearest instead of floor
// (saturating at all-ones); timing is identical in both builds.
module tt_um_pyth_leg
    import pyth_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    pyth_if.slave  bus
);

    logic [1:0]         state_q, state_d;
    logic [2*Width-1:0] r_sq_q, r_sq_d;
    logic [2*Width-1:0] x_sq_q, x_sq_d;
    logic [2*Width-1:0] diff_q, diff_d;
    logic [Width-1:0]   uo_q, uo_d;

    logic [2*Width-1:0] r_ext, x_ext;
    logic [Width-1:0]   root;
    logic [2*Width:0]   rem;
    logic [Width-1:0]   result;
    logic               sqrt_start;
    logic               sqrt_done;

    isqrt_seq #(
        .WIDTH (Width)
    ) u_isqrt (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena_i   (bus.ena),
        .start_i (sqrt_start),
        .diff_i  (diff_q),
        .root_o  (root),
        .rem_o   (rem),
        .done_o  (sqrt_done)
    );

`ifdef PYTH_LEG_ROUND_EN
    // rem = diff - root^2; rounding up is right when rem exceeds root
    // (rem == root + 0.25 would be the exact half, impossible for integers).
    assign result = ((rem > {{(Width + 1){1'b0}}, root}) && (root != '1)) ?
                    root + 1'b1 : root;
`else
    logic unused_rem;
    assign unused_rem = ^rem;
    assign result     = root;
`endif

    assign r_ext = {{Width{1'b0}}, bus.ui_in};
    assign x_ext = {{Width{1'b0}}, bus.uio_in};

    always_comb begin
        state_d    = state_q;
        r_sq_d     = r_sq_q;
        x_sq_d     = x_sq_q;
        diff_d     = diff_q;
        uo_d       = uo_q;
        sqrt_start = 1'b0;
        unique case (state_q)
            StCapture: begin
                r_sq_d  = r_ext * r_ext;
                x_sq_d  = x_ext * x_ext;
                state_d = StDiff;
            end
            StDiff: begin
                // Clamp instead of wrapping when the leg exceeds the hypotenuse.
                diff_d     = (x_sq_q > r_sq_q) ? '0 : r_sq_q - x_sq_q;
                sqrt_start = 1'b1;
                state_d    = StIter;
            end
            StIter: begin
                if (sqrt_done) begin
                    state_d = StOutput;
                end
            end
            StOutput: begin
                uo_d    = result;
                state_d = StCapture;
            end
            default: state_d = StCapture;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StCapture;
            r_sq_q  <= '0;
            x_sq_q  <= '0;
            diff_q  <= '0;
            uo_q    <= '0;
        end else if (bus.ena) begin
            state_q <= state_d;
            r_sq_q  <= r_sq_d;
            x_sq_q  <= x_sq_d;
            diff_q  <= diff_d;
            uo_q    <= uo_d;
        end
    end

    assign bus.uo_out  = uo_q;
    assign bus.uio_out = '0;
    assign bus.uio_oe  = '0;

endmodule

// File: tb/tb_tt_um_pyth_leg.sv
// Bench for tt_um_pyth_leg: a capture tracker pushes the expected leg into a
// scoreboard at every CAPTURE edge; a monitor pops and compares when the
// result is due and otherwise checks that uo_out holds.
module tb_tt_um_pyth_leg;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    pyth_if bus ();

    tt_um_pyth_leg dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   total    = 0;
    int   bad      = 0;
    int   sb[$];
    int   phase    = 0;      // enabled edges since the last CAPTURE, 0 = next edge captures
    logic out_edge = 1'b0;   // last posedge was the result edge
    int   req_id   = 0;
    int   taken_id = 0;
    int   pend_exp = 0;
    int   last_exp = 0;

    // Reference: other leg from plain integer arithmetic.
    function automatic int ref_leg(int r, int x);
        int d;
        int y;
        d = (x > r) ? 0 : r * r - x * x;
        y = 0;
        while ((y + 1) * (y + 1) <= d) y++;
`ifdef PYTH_LEG_ROUND_EN
        if ((d - y * y > y) && (y < 255)) y++;
`endif
        return y;
    endfunction

    // Capture tracker: one result per 11 enabled edges, captured at phase 0.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= 0;
            out_edge <= 1'b0;
            sb.delete();
        end else begin
            out_edge <= bus.ena && (phase == 10);
            if (bus.ena) begin
                if (phase == 0) begin
                    if (req_id != taken_id) begin
                        sb.push_back(pend_exp);
                        taken_id <= req_id;
                    end else begin
                        sb.push_back(ref_leg(int'(bus.ui_in), int'(bus.uio_in)));
                    end
                end
                phase <= (phase == 10) ? 0 : phase + 1;
            end
        end
    end

    task automatic chk(string nm, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
        end
    endtask

    // Monitor.
    always begin
        @(negedge clk or negedge rst_n);
        #1;
        if (!rst_n) begin
            last_exp = 0;
            chk("reset_uo", int'(bus.uo_out), 0);
        end else if (out_edge) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL result_unexpected got=%0d exp=none t=%0t", bus.uo_out, $time);
            end else begin
                last_exp = sb.pop_front();
                chk("result", int'(bus.uo_out), last_exp);
            end
        end else begin
            chk("hold", int'(bus.uo_out), last_exp);
        end
        chk("uio_out", int'(bus.uio_out), 0);
        chk("uio_oe", int'(bus.uio_oe), 0);
    end

    // Wait for the negedge before a CAPTURE edge, then present (r, x) with a
    // fixed expected leg.
    task automatic issue(int r, int x, int e);
        int n;
        n = 0;
        while (phase != 0 || !bus.ena) begin
            @(negedge clk);
            n++;
            if (n > 40) begin
                $display("FAIL issue_timeout got=phase%0d exp=phase0", phase);
                $fatal(1, "capture slot never reached");
            end
        end
        bus.ui_in  = 8'(r);
        bus.uio_in = 8'(x);
        pend_exp   = e;
        req_id++;
    endtask

    task automatic scramble(int n);
        repeat (n) begin
            @(negedge clk);
            bus.ui_in  = 8'($urandom);
            bus.uio_in = 8'($urandom);
        end
    endtask

    int dr[7] = '{5, 255, 200, 3, 7, 6, 13};
    int dx[7] = '{3, 0, 200, 5, 5, 4, 5};
`ifdef PYTH_LEG_ROUND_EN
    int de[7] = '{4, 255, 0, 0, 5, 4, 12};
`else
    int de[7] = '{4, 255, 0, 0, 4, 4, 12};
`endif

    initial begin
        bus.ena    = 1'b1;
        bus.ui_in  = '0;
        bus.uio_in = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases; pins are scrambled between captures.
        for (int i = 0; i < 7; i++) begin
            issue(dr[i], dx[i], de[i]);
            scramble(10);
        end

        // Freeze mid-ITER with pins changed; result must follow captured pins.
        issue(13, 5, 12);
        scramble(4);
        bus.ena = 1'b0;
        scramble(20);
        bus.ena = 1'b1;
        scramble(10);

        // Async reset mid-ITER, then first result 10 edges after first CAPTURE.
        issue(255, 0, 255);
        scramble(5);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(5, 3, 4);
        scramble(10);

        // Random sweep with random enable gaps and frequent x == r.
        for (int i = 0; i < 4400; i++) begin
            @(negedge clk);
            bus.ena    = ($urandom_range(0, 15) != 0);
            bus.ui_in  = 8'($urandom);
            bus.uio_in = ($urandom_range(0, 7) == 0) ? bus.ui_in : 8'($urandom);
        end
        bus.ena = 1'b1;
        scramble(24);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
